// File: rtl/buzzer_round_controller_if.sv
// Signal bundle between the host/button side and buzzer_round_controller.
// Optional FOUL_DETECT_EN adds the foul mask output.
interface buzzer_round_controller_if #(
    parameter int N_PLAYERS = 4
);
    logic                 start;
    logic                 clear;
    logic [N_PLAYERS-1:0] buzz;
    logic                 latch_en;
    logic                 busy;
    logic                 winner_valid;
    logic [2:0]           winner_id;
    logic                 timeout;
    logic [3:0]           seg_code;
    logic [1:0]           dbg_state;
`ifdef FOUL_DETECT_EN
    logic [N_PLAYERS-1:0] foul;

    modport master (
        output start, clear, buzz,
        input  latch_en, busy, winner_valid, winner_id, timeout, seg_code, dbg_state, foul
    );
    modport slave (
        input  start, clear, buzz,
        output latch_en, busy, winner_valid, winner_id, timeout, seg_code, dbg_state, foul
    );
`else
    modport master (
        output start, clear, buzz,
        input  latch_en, busy, winner_valid, winner_id, timeout, seg_code, dbg_state
    );
    modport slave (
        input  start, clear, buzz,
        output latch_en, busy, winner_valid, winner_id, timeout, seg_code, dbg_state
    );
`endif
endinterface

// File: rtl/buzzer_round_controller.sv
// Fastest-finger round sequencer: arms the latch, picks the lowest-index first press, locks out the rest.
// Optional feature macro FOUL_DETECT_EN masks players already holding their button at start.
module buzzer_round_controller #(
    parameter int N_PLAYERS   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic                      clk,
    input logic                      rst_n,
    buzzer_round_controller_if.slave bus
);
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TERM_CNT = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LOCKED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           winner_id_q, winner_id_d;
    logic [N_PLAYERS-1:0] meta_q, sync_q;
    logic [N_PLAYERS-1:0] cand;
    logic                 cand_any;
    logic [2:0]           cand_id;

    // Buttons are asynchronous; only the second flop feeds the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= bus.buzz;
            sync_q <= meta_q;
        end
    end

`ifdef FOUL_DETECT_EN
    logic [N_PLAYERS-1:0] foul_q, foul_d;

    assign cand = sync_q & ~foul_q;

    // Capture held buttons at start; a bit only drops once that player releases.
    always_comb begin
        foul_d = foul_q;
        if (state_q == S_IDLE) begin
            foul_d = (state_d == S_ARMED) ? sync_q : '0;
        end else if (state_d == S_IDLE) begin
            foul_d = '0;
        end else begin
            foul_d = foul_q & sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) foul_q <= '0;
        else        foul_q <= foul_d;
    end

    assign bus.foul = foul_q;
`else
    assign cand = sync_q;
`endif

    // Lowest index wins, matching the external priority encoder.
    always_comb begin
        cand_any = 1'b0;
        cand_id  = 3'd0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_any = 1'b1;
                cand_id  = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            winner_id_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            winner_id_q <= winner_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        winner_id_d = winner_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ARMED;
                    timer_d = '0;
                end
            end
            S_ARMED: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (cand_any) begin
                    state_d     = S_LOCKED;
                    winner_id_d = cand_id;
                end else if (timer_q == TERM_CNT) begin
                    state_d = S_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_LOCKED, S_TIMEOUT: begin
                if (bus.clear) begin
                    state_d     = S_IDLE;
                    timer_d     = '0;
                    winner_id_d = 3'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so they change only on the clock edge.
    assign bus.latch_en     = (state_q == S_ARMED);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.winner_valid = (state_q == S_LOCKED);
    assign bus.winner_id    = winner_id_q;
    assign bus.timeout      = (state_q == S_TIMEOUT);
    assign bus.seg_code     = (state_q == S_LOCKED)  ? (4'(winner_id_q) + 4'd1) :
                              (state_q == S_TIMEOUT) ? 4'hF : 4'h0;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_buzzer_round_controller.sv
// Directed bench: a long-timeout instance for press/lockout tests, an 8-cycle instance for timeout tests.
module tb_buzzer_round_controller;
    localparam int NP = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    buzzer_round_controller_if #(.N_PLAYERS(NP)) bl ();
    buzzer_round_controller_if #(.N_PLAYERS(NP)) bs ();

    buzzer_round_controller #(.N_PLAYERS(NP), .TIMEOUT_CYC(1000)) u_long (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bl.slave)
    );

    buzzer_round_controller #(.N_PLAYERS(NP), .TIMEOUT_CYC(8)) u_short (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Packs {busy, latch_en, winner_valid, timeout, winner_id, seg_code}.
    function automatic logic [31:0] pk_l();
        return {20'd0, bl.busy, bl.latch_en, bl.winner_valid, bl.timeout, 1'b0, bl.winner_id, bl.seg_code};
    endfunction
    function automatic logic [31:0] pk_s();
        return {20'd0, bs.busy, bs.latch_en, bs.winner_valid, bs.timeout, 1'b0, bs.winner_id, bs.seg_code};
    endfunction
    function automatic logic [31:0] ex(input logic b, input logic le, input logic wv, input logic to,
                                       input logic [2:0] id, input logic [3:0] seg);
        return {20'd0, b, le, wv, to, 1'b0, id, seg};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bl.start = 1'b0; bl.clear = 1'b0; bl.buzz = '0;
        bs.start = 1'b0; bs.clear = 1'b0; bs.buzz = '0;

        // Reset and idle
        tick(3);
        chk("reset_long", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        chk("reset_short", pk_s(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bl.buzz = 4'($urandom_range(0, 15));
            tick(1);
        end
        bl.buzz = '0;
        tick(4);
        chk("idle_buzz_ignored", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        chk("idle_state", 32'(bl.dbg_state), 32'd0);

        // Single press, exact 3-cycle latency
        bl.start = 1'b1; tick(1); bl.start = 1'b0;
        chk("armed", pk_l(), ex(1, 1, 0, 0, 3'd0, 4'h0));
        tick(9);
        bl.buzz = 4'b0100;
        tick(2);
        chk("press_lat2_still_armed", pk_l(), ex(1, 1, 0, 0, 3'd0, 4'h0));
        tick(1);
        chk("press_lat3_locked", pk_l(), ex(1, 0, 1, 0, 3'd2, 4'h3));
        bl.start = 1'b1; tick(1); bl.start = 1'b0;
        tick(1);
        chk("start_in_locked_ignored", pk_l(), ex(1, 0, 1, 0, 3'd2, 4'h3));
        bl.clear = 1'b1; tick(1); bl.clear = 1'b0;
        chk("clear_locked", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        bl.buzz = '0;
        tick(3);

        // Tie and lockout
        bl.start = 1'b1; tick(1); bl.start = 1'b0;
        tick(2);
        bl.buzz = 4'b1010;
        tick(3);
        chk("tie_lowest_wins", pk_l(), ex(1, 0, 1, 0, 3'd1, 4'h2));
        bl.buzz = 4'b1011;
        tick(4);
        chk("lockout_later_press", pk_l(), ex(1, 0, 1, 0, 3'd1, 4'h2));
        bl.clear = 1'b1; tick(1); bl.clear = 1'b0;
        chk("tie_clear", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        bl.buzz = '0;
        tick(3);

        // start and clear together in IDLE: start wins; then clear mid-ARMED
        bl.start = 1'b1; bl.clear = 1'b1; tick(1);
        bl.start = 1'b0; bl.clear = 1'b0;
        chk("start_beats_clear", pk_l(), ex(1, 1, 0, 0, 3'd0, 4'h0));
        tick(5);
        bl.clear = 1'b1; tick(1); bl.clear = 1'b0;
        chk("clear_mid_armed", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));

        // Timeout on the 8-cycle instance
        bs.start = 1'b1; tick(1); bs.start = 1'b0;
        tick(7);
        chk("pre_timeout_armed", pk_s(), ex(1, 1, 0, 0, 3'd0, 4'h0));
        tick(1);
        chk("timeout", pk_s(), ex(1, 0, 0, 1, 3'd0, 4'hF));
        bs.buzz = 4'b0010;
        tick(4);
        chk("press_after_timeout", pk_s(), ex(1, 0, 0, 1, 3'd0, 4'hF));
        bs.clear = 1'b1; tick(1); bs.clear = 1'b0;
        chk("clear_timeout", pk_s(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        bs.buzz = '0;
        tick(3);

        // Press synced on the terminal-count cycle: press wins
        bs.start = 1'b1; tick(1); bs.start = 1'b0;
        tick(5);
        bs.buzz = 4'b1000;
        tick(3);
        chk("press_at_terminal", pk_s(), ex(1, 0, 1, 0, 3'd3, 4'h4));
        bs.clear = 1'b1; tick(1); bs.clear = 1'b0;
        bs.buzz = '0;
        tick(3);

        // Button held across start
        bl.buzz = 4'b0001;
        tick(3);
        bl.start = 1'b1; tick(1); bl.start = 1'b0;
`ifdef FOUL_DETECT_EN
        chk("foul_mask", 32'(bl.foul), 32'h1);
        tick(1);
        chk("foul_no_win", pk_l(), ex(1, 1, 0, 0, 3'd0, 4'h0));
        bl.buzz = 4'b0101;
        tick(3);
        chk("foul_other_wins", pk_l(), ex(1, 0, 1, 0, 3'd2, 4'h3));
        bl.clear = 1'b1; tick(1); bl.clear = 1'b0;
        chk("foul_cleared", 32'(bl.foul), 32'h0);
`else
        tick(1);
        chk("held_wins_first", pk_l(), ex(1, 0, 1, 0, 3'd0, 4'h1));
        bl.buzz = 4'b0101;
        tick(3);
        chk("held_stays_winner", pk_l(), ex(1, 0, 1, 0, 3'd0, 4'h1));
        bl.clear = 1'b1; tick(1); bl.clear = 1'b0;
`endif
        chk("final_idle", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));

        // Asynchronous reset mid-round
        bl.buzz = '0;
        tick(3);
        bl.start = 1'b1; tick(1); bl.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", pk_l(), ex(0, 0, 0, 0, 3'd0, 4'h0));
        rst_n = 1'b1;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
